// File: rtl/io_write_buffer_pkg.sv
// Shared constants, state encoding and address decode helper for the IO write buffer.
package io_write_buffer_pkg;

  localparam int IO_DEPTH_WIDTH = 4;
  localparam int IO_FULL_MARGIN = 2;
  localparam int IO_STATE_WIDTH = 2;

  localparam logic [1:0] IO_ADDR_HI     = 2'b11;
  localparam logic       IO_DATA_OFFSET = 1'b0;
  localparam logic       IO_END_OFFSET  = 1'b1;

  typedef enum logic [IO_STATE_WIDTH-1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } io_state_e;

  // Only the two registers of the window decode; bit 2 selects data vs end marker.
  function automatic logic io_window_hit(input logic [17:0] addr);
    return (addr[17:16] == IO_ADDR_HI) && (addr[15:3] == 13'd0) && (addr[1:0] == 2'd0);
  endfunction

endpackage

// File: rtl/io_write_buffer_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and a first-word-fall-through head.
module byte_fifo
  import io_write_buffer_pkg::*;
#(
  parameter int DEPTH_WIDTH = IO_DEPTH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   valid,
  output logic                   full,
  output logic [DEPTH_WIDTH:0]   count
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [7:0]           mem_r [DEPTH];
  logic [DEPTH_WIDTH:0] head_r;
  logic [DEPTH_WIDTH:0] tail_r;
  logic                 empty_s;
  logic                 pop_s;

  assign empty_s = (head_r == tail_r);
  assign full    = (head_r[DEPTH_WIDTH] != tail_r[DEPTH_WIDTH]) &&
                   (head_r[DEPTH_WIDTH-1:0] == tail_r[DEPTH_WIDTH-1:0]);
  assign count   = tail_r - head_r;
  assign valid   = !empty_s;
  assign pop_s   = pop && !empty_s;
  // Head entry is read before the same-edge overwrite, so push+pop while full is safe.
  assign dout    = empty_s ? 8'h00 : mem_r[head_r[DEPTH_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      if (push) begin
        tail_r <= tail_r + (DEPTH_WIDTH+1)'(1);
      end
      if (pop_s) begin
        head_r <= head_r + (DEPTH_WIDTH+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[tail_r[DEPTH_WIDTH-1:0]] <= din;
    end
  end

endmodule

// File: rtl/io_write_buffer.sv
// Captures cpu writes to the IO window, queues them for the UART and sequences the program-end halt.
module io_write_buffer
  import io_write_buffer_pkg::*;
#(
  parameter int DEPTH_WIDTH = IO_DEPTH_WIDTH,
  parameter int FULL_MARGIN = IO_FULL_MARGIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] cpu_mem_a,
  input  logic [7:0]  cpu_mem_dout,
  input  logic        cpu_mem_wr,
  input  logic        uart_tx_ready,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  output logic        io_buffer_full,
  output logic        io_halt,
  output logic [7:0]  io_exit_code,
  output logic        io_overflow
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_LEVEL = (DEPTH_WIDTH+1)'(DEPTH - FULL_MARGIN);
  localparam logic [DEPTH_WIDTH:0] ZERO_COUNT = (DEPTH_WIDTH+1)'(0);

  io_state_e            state_r;
  io_state_e            next_state_s;
  logic                 io_hit_s;
  logic                 data_wr_s;
  logic                 end_wr_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 drop_s;
  logic                 fifo_full_s;
  logic [DEPTH_WIDTH:0] count_s;
  logic [DEPTH_WIDTH:0] next_count_s;
  logic                 drained_s;
  logic                 full_r;
  logic                 halt_r;
  logic [7:0]           exit_code_r;
  logic                 overflow_r;
  logic                 unused_addr_s;

  assign unused_addr_s = ^cpu_mem_a[31:18];
  assign io_hit_s      = cpu_mem_wr && io_window_hit(cpu_mem_a[17:0]);
  assign data_wr_s     = io_hit_s && (cpu_mem_a[2] == IO_DATA_OFFSET);
  assign end_wr_s      = io_hit_s && (cpu_mem_a[2] == IO_END_OFFSET);
  assign pop_s         = rdy && uart_tx_valid && uart_tx_ready;
  assign next_count_s  = count_s + (DEPTH_WIDTH+1)'(push_s) - (DEPTH_WIDTH+1)'(pop_s);
  assign drained_s     = ((count_s - (DEPTH_WIDTH+1)'(pop_s)) == ZERO_COUNT);

  byte_fifo #(
    .DEPTH_WIDTH(DEPTH_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cpu_mem_dout),
    .dout  (uart_tx_data),
    .valid (uart_tx_valid),
    .full  (fifo_full_s),
    .count (count_s)
  );

  // Next-state, push and drop decisions; an end write wins over a data write.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    if (rdy) begin
      case (state_r)
        ST_RUN: begin
          if (end_wr_s) begin
            next_state_s = ST_DRAIN;
          end else if (data_wr_s) begin
            if (!fifo_full_s || pop_s) begin
              push_s = 1'b1;
            end else begin
              drop_s = 1'b1;
            end
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          drop_s = data_wr_s;
          if (drained_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          next_state_s = ST_DONE;
        end
        default: begin
          next_state_s = ST_RUN;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State register, registered back-pressure and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      full_r      <= 1'b0;
      halt_r      <= 1'b0;
      exit_code_r <= 8'h00;
      overflow_r  <= 1'b0;
    end else if (rdy) begin
      state_r <= next_state_s;
      full_r  <= (next_count_s >= FULL_LEVEL);
      halt_r  <= (next_state_s == ST_DONE);
      if ((state_r == ST_RUN) && end_wr_s) begin
        exit_code_r <= cpu_mem_dout;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign io_buffer_full = full_r;
  assign io_halt        = halt_r;
  assign io_exit_code   = exit_code_r;
  assign io_overflow    = overflow_r;

endmodule
